// File: rtl/mem_access_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// One grant at a time, alternating priority, with a watchdog and sticky fault.
module mem_access_arbiter #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IGNT  = 2'd1;
    localparam logic [1:0] S_DGNT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [1:0]       state, next_state;
    logic             last_d, next_last_d;
    logic [CNT_W-1:0] wcnt, next_wcnt;

    logic ip, dp, i_live, d_live, ram_access, ram_error;

    // Ties go to whichever side did not complete last.
    function automatic logic [1:0] grant_select(input logic ip_f, input logic dp_f,
                                                input logic ld);
        if (ip_f && dp_f) return ld ? S_IGNT : S_DGNT;
        else if (dp_f)    return S_DGNT;
        else if (ip_f)    return S_IGNT;
        else              return S_IDLE;
    endfunction

    assign ip         = iREN & ~halt;
    assign dp         = dREN | dWEN;
    assign i_live     = (state == S_IGNT) & iREN;
    assign d_live     = (state == S_DGNT) & dp;
    assign ram_access = (ramstate == RAM_ACCESS);
    assign ram_error  = (ramstate == RAM_ERROR);

    // A granted requester that drops its strobe releases the RAM in the same cycle.
    always_comb begin
        ihit     = i_live & ram_access;
        dhit     = d_live & ram_access;
        iload    = ihit ? ramload : 32'd0;
        dload    = (dhit && !dWEN) ? ramload : 32'd0;
        ramREN   = i_live | (d_live & ~dWEN);
        ramWEN   = d_live & dWEN;
        ramstore = (d_live && dWEN) ? dstore : 32'd0;
        fault    = (state == S_FAULT);
        ramaddr  = 32'd0;
        if (state == S_IGNT)      ramaddr = iaddr;
        else if (state == S_DGNT) ramaddr = daddr;
    end

    always_comb begin
        next_state  = state;
        next_last_d = last_d;
        next_wcnt   = wcnt;
        case (state)
            S_IDLE: begin
                next_state = grant_select(ip, dp, last_d);
                next_wcnt  = '0;
            end
            S_IGNT, S_DGNT: begin
                if (ram_error) begin
                    next_state = S_FAULT;
                end else if (ihit || dhit) begin
                    next_last_d = dhit;
                    next_state  = grant_select(ip, dp, dhit);
                    next_wcnt   = '0;
                end else if (!(i_live || d_live)) begin
                    next_state = grant_select(ip, dp, last_d);
                    next_wcnt  = '0;
                end else if (wcnt == WAIT_LAST) begin
                    next_state = S_FAULT;
                end else begin
                    next_wcnt = wcnt + 1'b1;
                end
            end
            default: next_state = S_FAULT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            last_d <= 1'b0;
            wcnt   <= '0;
        end else begin
            state  <= next_state;
            last_d <= next_last_d;
            wcnt   <= next_wcnt;
        end
    end

endmodule
